// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: FWFT byte FIFO, sticky line status, break collapse, timeout, irq
module uart_rx_ctrl #(
   parameter int DataBits      = 8,
   parameter int Depth         = 4,
   parameter int TimeoutCycles = 64,
   parameter int IrqThreshold  = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DataBits-1:0]        rx_data,
   input  logic                       rx_valid,
   input  logic                       rx_break,
   input  logic                       rx_error,
   input  logic                       enable,
   input  logic                       flush,
   input  logic                       clear_status,
   output logic [DataBits-1:0]        m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(Depth+1)-1:0] level,
   output logic                       overrun,
   output logic                       frame_err,
   output logic                       break_det,
   output logic                       timeout,
   output logic                       irq
);

   localparam int LW = $clog2(Depth + 1);
   localparam int PW = $clog2(Depth);
   localparam int TW = $clog2(TimeoutCycles + 1);

   typedef enum logic {
      RUN      = 1'b0,
      IN_BREAK = 1'b1
   } state_t;

   state_t              state;
   logic [DataBits-1:0] mem [Depth];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [TW-1:0]       tcnt;

   logic          full;
   logic          pop;
   logic          push;
   logic          ovr_set;
   logic          brk_set;
   logic          fe_set;
   logic [LW-1:0] level_n;
   logic [TW-1:0] tcnt_n;
   logic          timeout_n;
   logic          ovr_n;
   logic          fe_n;
   logic          brk_n;

   // Head is only meaningful while non-empty; an empty FIFO presents zero.
   assign m_valid = (level != '0);
   assign m_data  = m_valid ? mem[rd_ptr] : '0;

   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign full    = (level == LW'(Depth));
   assign pop     = m_valid & m_ready;
   assign push    = enable & rx_valid & (~full | pop);
   assign ovr_set = enable & rx_valid & full & ~pop;
   // Break and error reports are swallowed while the line is still held in break.
   assign brk_set = enable & (state == RUN) & rx_break;
   assign fe_set  = enable & (state == RUN) & rx_error;

   // Next-state occupancy, idle counter and sticky bits; irq is derived from these.
   always_comb begin
      level_n = level;
      if (flush) begin
         level_n = '0;
      end else if (push && !pop) begin
         level_n = level + LW'(1);
      end else if (pop && !push) begin
         level_n = level - LW'(1);
      end

      tcnt_n = tcnt;
      if (push || pop || flush || (level == '0)) begin
         tcnt_n = '0;
      end else if (tcnt != TW'(TimeoutCycles)) begin
         tcnt_n = tcnt + TW'(1);
      end
      timeout_n = (tcnt_n == TW'(TimeoutCycles));

      ovr_n = ovr_set | (overrun   & ~clear_status);
      fe_n  = fe_set  | (frame_err & ~clear_status);
      brk_n = brk_set | (break_det & ~clear_status);
   end

   // Storage is written without reset; stale contents are never visible past level.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   // FIFO pointers, occupancy and the character timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         tcnt    <= '0;
         timeout <= 1'b0;
      end else begin
         level   <= level_n;
         tcnt    <= tcnt_n;
         timeout <= timeout_n;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Break FSM plus the sticky status bits and the registered interrupt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         break_det <= 1'b0;
         irq       <= 1'b0;
      end else begin
         overrun   <= ovr_n;
         frame_err <= fe_n;
         break_det <= brk_n;
         irq       <= (level_n >= LW'(IrqThreshold)) | timeout_n | ovr_n | fe_n | brk_n;
         if (!enable) begin
            state <= RUN;
         end else begin
            case (state)
               RUN:      if (rx_break) state <= IN_BREAK;
               IN_BREAK: if (rx_valid) state <= RUN;
               default:  state <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a queue-based reference model
module tb_uart_rx_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int TMO   = 64;
   localparam int THR   = 1;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_break = 1'b0;
   logic          rx_error = 1'b0;
   logic          enable = 1'b1;
   logic          flush = 1'b0;
   logic          clear_status = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [LW-1:0] level;
   logic          overrun;
   logic          frame_err;
   logic          break_det;
   logic          timeout;
   logic          irq;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [DW-1:0] mq[$];
   bit            mo, mf, mb, minb, mt, mirq;
   int            mi;

   uart_rx_ctrl #(
      .DataBits(DW), .Depth(DEPTH), .TimeoutCycles(TMO), .IrqThreshold(THR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_break(rx_break), .rx_error(rx_error), .enable(enable), .flush(flush),
      .clear_status(clear_status), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .level(level), .overrun(overrun), .frame_err(frame_err),
      .break_det(break_det), .timeout(timeout), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      mq.delete();
      mo = 0; mf = 0; mb = 0; minb = 0; mt = 0; mirq = 0; mi = 0;
   endtask

   task automatic model_step();
      int sz;
      bit pop, acc, ovs, bs, es;
      sz  = mq.size();
      pop = (sz > 0) && m_ready;
      acc = enable && rx_valid && (sz < DEPTH || pop);
      ovs = enable && rx_valid && (sz == DEPTH) && !pop;
      bs  = enable && !minb && rx_break;
      es  = enable && !minb && rx_error;
      if (acc || pop || flush || sz == 0) mi = 0;
      else if (mi < TMO) mi = mi + 1;
      if (flush) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(rx_data);
      end
      mo = ovs || (mo && !clear_status);
      mf = es  || (mf && !clear_status);
      mb = bs  || (mb && !clear_status);
      if (!enable) minb = 0;
      else if (!minb && rx_break) minb = 1;
      else if (minb && rx_valid) minb = 0;
      mt   = (mi == TMO);
      mirq = (mq.size() >= THR) || mt || mo || mf || mb;
   endtask

   task automatic idle_inputs();
      rx_valid = 0; rx_break = 0; rx_error = 0; rx_data = '0;
      enable = 1; flush = 0; clear_status = 0; m_ready = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      model_clear();
   endtask

   task automatic push_byte(input logic [DW-1:0] d);
      rx_valid = 1; rx_data = d;
      tick();
      rx_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (level !== '0)     begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      n_cmp++; if (m_data !== '0)    begin n_err++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
      n_cmp++; if ({overrun, frame_err, break_det, timeout, irq} !== 5'b0)
         begin n_err++; $display("FAIL reset_status got=%b exp=00000", {overrun, frame_err, break_det, timeout, irq}); end
   endtask

   task automatic test_fifo_order();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push_byte(DW'(8'h41 + i));
         n_cmp++; if (level !== LW'(i + 1)) begin n_err++; $display("FAIL order_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
         n_cmp++; if (m_data !== 8'h41) begin n_err++; $display("FAIL order_head[%0d] got=%h exp=41", i, m_data); end
         n_cmp++; if (irq !== 1'b1)     begin n_err++; $display("FAIL order_irq[%0d] got=%b exp=1", i, irq); end
      end
      m_ready = 1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (m_valid !== 1'b1 || m_data !== DW'(8'h41 + i))
            begin n_err++; $display("FAIL order_drain[%0d] got=%b/%h exp=1/%h", i, m_valid, m_data, 8'h41 + i); end
         tick();
      end
      m_ready = 0;
      n_cmp++; if (m_valid !== 1'b0 || level !== '0) begin n_err++; $display("FAIL order_empty got=%b/%0d exp=0/0", m_valid, level); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL order_irq_low got=%b exp=0", irq); end
   endtask

   task automatic test_overrun();
      do_reset();
      for (int i = 0; i < 4; i++) push_byte(DW'(8'h10 + i));
      n_cmp++; if (level !== LW'(4)) begin n_err++; $display("FAIL ovr_full got=%0d exp=4", level); end
      push_byte(8'h14);
      n_cmp++; if (level !== LW'(4) || overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%0d/%b exp=4/1", level, overrun); end
      n_cmp++; if (m_data !== 8'h10) begin n_err++; $display("FAIL ovr_head got=%h exp=10", m_data); end
      clear_status = 1; tick(); clear_status = 0;
      n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
      m_ready = 1; push_byte(8'h14);
      n_cmp++; if (level !== LW'(4) || overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pushpop got=%0d/%b exp=4/0", level, overrun); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (m_data !== DW'(8'h11 + i)) begin n_err++; $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, m_data, 8'h11 + i); end
         tick();
      end
      m_ready = 0;
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL ovr_empty got=%b exp=0", m_valid); end
   endtask

   task automatic test_break();
      do_reset();
      rx_break = 1; tick(); rx_break = 0;
      n_cmp++; if (break_det !== 1'b1 || irq !== 1'b1) begin n_err++; $display("FAIL brk_set got=%b/%b exp=1/1", break_det, irq); end
      clear_status = 1; tick(); clear_status = 0;
      n_cmp++; if (break_det !== 1'b0) begin n_err++; $display("FAIL brk_clear got=%b exp=0", break_det); end
      rx_break = 1; tick(); rx_break = 0; rx_error = 1; tick(); rx_error = 0; rx_break = 1; tick(); rx_break = 0;
      n_cmp++; if (break_det !== 1'b0 || frame_err !== 1'b0) begin n_err++; $display("FAIL brk_hold got=%b/%b exp=0/0", break_det, frame_err); end
      push_byte(8'h55);
      n_cmp++; if (level !== LW'(1) || m_data !== 8'h55) begin n_err++; $display("FAIL brk_exit got=%0d/%h exp=1/55", level, m_data); end
      rx_break = 1; tick(); rx_break = 0;
      n_cmp++; if (break_det !== 1'b1) begin n_err++; $display("FAIL brk_reset got=%b exp=1", break_det); end
   endtask

   task automatic test_timeout();
      do_reset();
      push_byte(8'h5a);
      repeat (TMO - 1) tick();
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_early got=%b exp=0", timeout); end
      tick();
      n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_hit got=%b exp=1", timeout); end
      tick();
      n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_sat got=%b exp=1", timeout); end
      m_ready = 1; tick(); m_ready = 0;
      n_cmp++; if (timeout !== 1'b0 || level !== '0) begin n_err++; $display("FAIL tmo_pop got=%b/%0d exp=0/0", timeout, level); end
   endtask

   task automatic test_flush();
      do_reset();
      rx_error = 1; tick(); rx_error = 0;
      push_byte(8'ha1); push_byte(8'ha2);
      n_cmp++; if (level !== LW'(2) || frame_err !== 1'b1) begin n_err++; $display("FAIL fl_setup got=%0d/%b exp=2/1", level, frame_err); end
      flush = 1; push_byte(8'ha3); flush = 0;
      n_cmp++; if (level !== '0 || m_valid !== 1'b0 || m_data !== '0) begin n_err++; $display("FAIL fl_level got=%0d/%b/%h exp=0/0/00", level, m_valid, m_data); end
      n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL fl_sticky got=%b exp=1", frame_err); end
      tick();
      n_cmp++; if (level !== '0) begin n_err++; $display("FAIL fl_absent got=%0d exp=0", level); end
      clear_status = 1; rx_error = 1; tick(); rx_error = 0;
      n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL fl_setwins got=%b exp=1", frame_err); end
      tick(); clear_status = 0;
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL fl_clear got=%b exp=0", frame_err); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) push_byte(DW'(8'h20 + i));
      m_ready = 1; tick(); m_ready = 0;
      n_cmp++; if (level !== LW'(3) || overrun !== 1'b1) begin n_err++; $display("FAIL ar_setup got=%0d/%b exp=3/1", level, overrun); end
      #2 rst_n = 0;
      #1;
      n_cmp++; if (level !== '0 || m_valid !== 1'b0 || m_data !== '0) begin n_err++; $display("FAIL ar_fifo got=%0d/%b/%h exp=0/0/00", level, m_valid, m_data); end
      n_cmp++; if ({overrun, frame_err, break_det, timeout, irq} !== 5'b0)
         begin n_err++; $display("FAIL ar_status got=%b exp=00000", {overrun, frame_err, break_det, timeout, irq}); end
      #2 rst_n = 1;
      @(posedge clk); #1;
      model_clear();
      enable = 0; rx_valid = 1; rx_data = 8'h77; rx_error = 1;
      tick(); tick();
      rx_valid = 0; rx_error = 0; rx_break = 1; tick(); rx_break = 0; enable = 1;
      n_cmp++; if (level !== '0 || frame_err !== 1'b0 || break_det !== 1'b0)
         begin n_err++; $display("FAIL ar_disabled got=%0d/%b/%b exp=0/0/0", level, frame_err, break_det); end
   endtask

   task automatic test_random();
      int mode, pv, r;
      logic [DW-1:0] ed;
      do_reset();
      mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 150 == 0) mode = $urandom_range(0, 2);
         pv = (mode == 0) ? 50 : 35;
         r  = $urandom_range(0, 99);
         rx_data      = DW'($urandom);
         rx_valid     = (mode != 2) && (r < pv);
         rx_break     = (mode != 2) && (r >= pv) && (r < pv + 4);
         rx_error     = (mode != 2) && (r >= pv + 4) && (r < pv + 9);
         enable       = (mode == 2) || ($urandom_range(0, 19) != 0);
         flush        = (mode != 2) && ($urandom_range(0, 49) == 0);
         clear_status = (mode != 2) && ($urandom_range(0, 19) == 0);
         m_ready      = (mode == 0) ? ($urandom_range(0, 4) == 0) : (mode == 1) ? ($urandom_range(0, 9) < 6) : 1'b0;
         tick();
         ed = (mq.size() > 0) ? mq[0] : '0;
         n_cmp++; if (level !== LW'(mq.size()))  begin n_err++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, mq.size()); end
         n_cmp++; if (m_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_m_valid c=%0d got=%b exp=%b", c, m_valid, mq.size() > 0); end
         n_cmp++; if (m_data !== ed)             begin n_err++; $display("FAIL rnd_m_data c=%0d got=%h exp=%h", c, m_data, ed); end
         n_cmp++; if (overrun !== mo)            begin n_err++; $display("FAIL rnd_overrun c=%0d got=%b exp=%b", c, overrun, mo); end
         n_cmp++; if (frame_err !== mf)          begin n_err++; $display("FAIL rnd_frame_err c=%0d got=%b exp=%b", c, frame_err, mf); end
         n_cmp++; if (break_det !== mb)          begin n_err++; $display("FAIL rnd_break_det c=%0d got=%b exp=%b", c, break_det, mb); end
         n_cmp++; if (timeout !== mt)            begin n_err++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, timeout, mt); end
         n_cmp++; if (irq !== mirq)              begin n_err++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, mirq); end
      end
      idle_inputs();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_fifo_order();
      test_overrun();
      test_break();
      test_timeout();
      test_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
